// File: rtl/adc_chan_cond_if.sv
// Sample/control bundle between an ADC channel conditioner and its driver/consumer.
// master drives the raw sample and acquisition controls; slave is the conditioner.
interface adc_chan_cond_if #(
    parameter int WIN_W = 8
);
    logic        [12:0]      data_in_del;
    logic                    trig;
    logic                    ped_en;
    logic        [WIN_W-1:0] win_len;
    logic signed [12:0]      data_out;
    logic                    store_strb;
    logic signed [12:0]      ped_out;
    logic                    busy;
    logic                    done;
    logic                    trig_err;

    modport master (
        output data_in_del, trig, ped_en, win_len,
        input  data_out, store_strb, ped_out, busy, done, trig_err
    );

    modport slave (
        input  data_in_del, trig, ped_en, win_len,
        output data_out, store_strb, ped_out, busy, done, trig_err
    );
endinterface

// File: rtl/adc_chan_cond.sv
// Per-channel ADC conditioning: bit-inversion undo, pedestal averaging on trigger,
// and a pedestal-subtracted, saturated sample stream gated by a store window.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for trig; data_out free-runs with store_strb low
// S_PED   | accumulating 2**PED_LOG2 samples for the pedestal average
// S_STORE | window enable high for win_len cycles, then done pulse
module adc_chan_cond #(
    parameter logic [12:0] BITFLIP  = 13'h1000,
    parameter int          PED_LOG2 = 4,
    parameter int          WIN_W    = 8
) (
    input  logic            clk357,
    input  logic            rst,
    adc_chan_cond_if.slave  bus
);
    localparam int ACC_W = 13 + PED_LOG2;
    localparam int CNT_W = (WIN_W > 7) ? WIN_W : 7;
    localparam int N_M1  = (1 << PED_LOG2) - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PED   = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;

    logic        [12:0]      s1_q, s1_d;
    logic signed [12:0]      c_q, c_d;
    logic        [1:0]       state_q, state_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [WIN_W-1:0] win_q, win_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [12:0]      ped_q, ped_d;
    logic signed [12:0]      ped_out_q, ped_out_d;
    logic signed [12:0]      dout_q, dout_d;
    logic                    strb_q, strb_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic signed [ACC_W-1:0] acc_sum;
    logic signed [12:0]      ped_new;
    logic signed [13:0]      diff;
    logic                    win_en;

    always_comb begin
        s1_d      = bus.data_in_del;
        c_d       = $signed(s1_q ^ BITFLIP);
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        acc_d     = acc_q;
        ped_d     = ped_q;
        ped_out_d = ped_out_q;
        err_d     = err_q;
        done_d    = 1'b0;

        acc_sum = acc_q + ACC_W'(c_q);
        ped_new = 13'(acc_sum >>> PED_LOG2);
        win_en  = (state_q == S_STORE) && (cnt_q != '0);

        // 14-bit difference cannot wrap; clamp back into the 13-bit range
        diff = 14'(c_q) - 14'(ped_q);
        if (diff > 14'sd4095) begin
            dout_d = 13'sh0FFF;
        end else if (diff < -14'sd4096) begin
            dout_d = 13'sh1000;
        end else begin
            dout_d = diff[12:0];
        end

        case (state_q)
            S_IDLE: begin
                if (bus.trig) begin
                    win_d = bus.win_len;
                    if (bus.ped_en) begin
                        state_d = S_PED;
                        cnt_d   = CNT_W'(N_M1);
                        acc_d   = '0;
                    end else begin
                        state_d = S_STORE;
                        ped_d   = '0;
                        cnt_d   = CNT_W'(bus.win_len);
                    end
                end
            end
            S_PED: begin
                if (bus.trig) err_d = 1'b1;
                acc_d = acc_sum;
                if (cnt_q == '0) begin
                    ped_d     = ped_new;
                    ped_out_d = ped_new;
                    acc_d     = '0;
                    state_d   = S_STORE;
                    cnt_d     = CNT_W'(win_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STORE: begin
                if (bus.trig) err_d = 1'b1;
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        strb_d = win_en;
    end

    always_ff @(posedge clk357) begin
        if (rst) begin
            s1_q      <= '0;
            c_q       <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            acc_q     <= '0;
            ped_q     <= '0;
            ped_out_q <= '0;
            dout_q    <= '0;
            strb_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            c_q       <= c_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            ped_q     <= ped_d;
            ped_out_q <= ped_out_d;
            dout_q    <= dout_d;
            strb_q    <= strb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.store_strb = strb_q;
    assign bus.ped_out    = ped_out_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trig_err   = err_q;
endmodule
